// File: rtl/bru_issue_sched_pkg.sv
// Shared sizing and payload layout for the branch issue queue, so dispatch
// and the branch unit slice the opaque payload identically.
package bru_issue_sched_pkg;
  localparam int BRU_IQ_DEPTH = 8;
  localparam int BRU_TAG_W    = 7;
  localparam int BRU_ROB_W    = 6;
  localparam int BRU_PAY_W    = 106;
  localparam int BRU_NWAKE    = 5;

  // Payload field offsets: pc | op | imm26 | rd able | rd tag | mode | redir
  localparam int PAY_PC_LSB    = 0;
  localparam int PAY_PC_W      = 32;
  localparam int PAY_OP_LSB    = 32;
  localparam int PAY_OP_W      = 6;
  localparam int PAY_IMM_LSB   = 38;
  localparam int PAY_IMM_W     = 26;
  localparam int PAY_RDA_LSB   = 64;
  localparam int PAY_RD_LSB    = 65;
  localparam int PAY_RD_W      = 7;
  localparam int PAY_MODE_LSB  = 72;
  localparam int PAY_MODE_W    = 2;
  localparam int PAY_REDIR_LSB = 74;
  localparam int PAY_REDIR_W   = 32;
endpackage

// File: rtl/bru_issue_sched_if.sv
// Dispatch, wakeup and branch-unit issue bundle of the branch issue queue.
interface bru_issue_sched_if #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 7,
  parameter int ROB_W = 6,
  parameter int PAY_W = 106,
  parameter int NWAKE = 5
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                   BruFlash;
  logic [ROB_W-1:0]       RobHeadPtr;
  logic                   EnqValid;
  logic                   EnqReady;
  logic                   EnqSrc1Able, EnqSrc2Able;
  logic [TAG_W-1:0]       EnqSrc1Addr, EnqSrc2Addr;
  logic                   EnqSrc1Rdy, EnqSrc2Rdy;
  logic [ROB_W-1:0]       EnqRobPtr;
  logic [PAY_W-1:0]       EnqPayload;
  logic [NWAKE-1:0]       WakeAble;
  logic [NWAKE*TAG_W-1:0] WakeAddr;
  logic                   BruReqInst;
  logic                   IssValid;
  logic                   IssSrc1Able, IssSrc2Able;
  logic [TAG_W-1:0]       IssSrc1Addr, IssSrc2Addr;
  logic [ROB_W-1:0]       IssRobPtr;
  logic [PAY_W-1:0]       IssPayload;
  logic [CNT_W-1:0]       Occupancy;

  modport slave (
    input  BruFlash, RobHeadPtr, EnqValid, EnqSrc1Able, EnqSrc2Able,
           EnqSrc1Addr, EnqSrc2Addr, EnqSrc1Rdy, EnqSrc2Rdy, EnqRobPtr,
           EnqPayload, WakeAble, WakeAddr, BruReqInst,
    output EnqReady, IssValid, IssSrc1Able, IssSrc2Able, IssSrc1Addr,
           IssSrc2Addr, IssRobPtr, IssPayload, Occupancy
  );

  modport master (
    output BruFlash, RobHeadPtr, EnqValid, EnqSrc1Able, EnqSrc2Able,
           EnqSrc1Addr, EnqSrc2Addr, EnqSrc1Rdy, EnqSrc2Rdy, EnqRobPtr,
           EnqPayload, WakeAble, WakeAddr, BruReqInst,
    input  EnqReady, IssValid, IssSrc1Able, IssSrc2Able, IssSrc1Addr,
           IssSrc2Addr, IssRobPtr, IssPayload, Occupancy
  );
endinterface

// File: rtl/bru_issue_sched_age_select.sv
// Oldest-eligible picker: minimum (rob - head) mod 2^ROB_W, lowest index on tie.
module bru_age_select #(
  parameter int DEPTH = 8,
  parameter int ROB_W = 6
) (
  input  logic [DEPTH-1:0]            i_elig,
  input  logic [DEPTH-1:0][ROB_W-1:0] i_rob,
  input  logic [ROB_W-1:0]            i_head,
  output logic [DEPTH-1:0]            o_gnt,
  output logic                        o_vld
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [ROB_W-1:0] w_age, w_best;
  logic [IDX_W-1:0] w_idx;

  always_comb begin
    w_age = '0;
    w_best = '1;
    w_idx = '0;
    o_vld = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_age = i_rob[i] - i_head;
      // strict compare keeps the lower index on an age tie
      if (i_elig[i] && (!o_vld || w_age < w_best)) begin
        w_best = w_age;
        w_idx  = IDX_W'(i);
        o_vld  = 1'b1;
      end
    end
    o_gnt = o_vld ? (DEPTH'(1) << w_idx) : '0;
  end
endmodule

// File: rtl/bru_issue_sched.sv
// Branch issue queue: tracks operand readiness via wakeup CAM and issues the
// oldest ready micro-op per cycle into a registered branch-unit issue port.
module bru_issue_sched
  import bru_issue_sched_pkg::*;
#(
  parameter int DEPTH = BRU_IQ_DEPTH,
  parameter int TAG_W = BRU_TAG_W,
  parameter int ROB_W = BRU_ROB_W,
  parameter int PAY_W = BRU_PAY_W,
  parameter int NWAKE = BRU_NWAKE
) (
  input  logic             Clk,
  input  logic             Rest,
  bru_issue_sched_if.slave io
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0]            r_vld, r_s1a, r_s2a, r_s1r, r_s2r;
  logic [DEPTH-1:0][TAG_W-1:0] r_s1t, r_s2t;
  logic [DEPTH-1:0][ROB_W-1:0] r_rob;
  logic [DEPTH-1:0][PAY_W-1:0] r_pay;
  logic [CNT_W-1:0]            r_cnt;

  logic             r_iss_vld, r_iss_s1a, r_iss_s2a;
  logic [TAG_W-1:0] r_iss_s1t, r_iss_s2t;
  logic [ROB_W-1:0] r_iss_rob;
  logic [PAY_W-1:0] r_iss_pay;

  logic [DEPTH-1:0] w_wk1, w_wk2, w_elig, w_gnt, w_free_oh;
  logic             w_enq_wk1, w_enq_wk2, w_enq_rdy, w_enq, w_sel_vld, w_iss;
  logic [IDX_W-1:0] w_free_idx;
  logic             w_sel_s1a, w_sel_s2a;
  logic [TAG_W-1:0] w_sel_s1t, w_sel_s2t;
  logic [ROB_W-1:0] w_sel_rob;
  logic [PAY_W-1:0] w_sel_pay;

  // Wakeup CAM over resident entries and the incoming dispatch slot
  always_comb begin
    w_wk1 = '0;
    w_wk2 = '0;
    w_enq_wk1 = 1'b0;
    w_enq_wk2 = 1'b0;
    for (int b = 0; b < NWAKE; b++) begin
      if (io.WakeAble[b]) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_s1a[i] && r_s1t[i] == io.WakeAddr[b*TAG_W +: TAG_W]) w_wk1[i] = 1'b1;
          if (r_s2a[i] && r_s2t[i] == io.WakeAddr[b*TAG_W +: TAG_W]) w_wk2[i] = 1'b1;
        end
        if (io.EnqSrc1Addr == io.WakeAddr[b*TAG_W +: TAG_W]) w_enq_wk1 = 1'b1;
        if (io.EnqSrc2Addr == io.WakeAddr[b*TAG_W +: TAG_W]) w_enq_wk2 = 1'b1;
      end
    end
  end

  always_comb begin
    w_free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!r_vld[i]) w_free_idx = IDX_W'(i);
  end

  assign w_free_oh = DEPTH'(1) << w_free_idx;
  assign w_enq_rdy = (r_cnt < CNT_W'(DEPTH));
  assign w_enq     = io.EnqValid & w_enq_rdy;
  assign w_elig    = r_vld & r_s1r & r_s2r;
  assign w_iss     = io.BruReqInst & w_sel_vld;

  bru_age_select #(.DEPTH(DEPTH), .ROB_W(ROB_W)) u_age_sel (
    .i_elig (w_elig),
    .i_rob  (r_rob),
    .i_head (io.RobHeadPtr),
    .o_gnt  (w_gnt),
    .o_vld  (w_sel_vld)
  );

  always_comb begin
    w_sel_s1a = 1'b0;
    w_sel_s2a = 1'b0;
    w_sel_s1t = '0;
    w_sel_s2t = '0;
    w_sel_rob = '0;
    w_sel_pay = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_gnt[i]) begin
        w_sel_s1a = w_sel_s1a | r_s1a[i];
        w_sel_s2a = w_sel_s2a | r_s2a[i];
        w_sel_s1t = w_sel_s1t | r_s1t[i];
        w_sel_s2t = w_sel_s2t | r_s2t[i];
        w_sel_rob = w_sel_rob | r_rob[i];
        w_sel_pay = w_sel_pay | r_pay[i];
      end
    end
  end

  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      r_vld     <= '0;
      r_cnt     <= '0;
      r_iss_vld <= 1'b0;
      r_iss_s1a <= 1'b0;
      r_iss_s2a <= 1'b0;
      r_iss_s1t <= '0;
      r_iss_s2t <= '0;
      r_iss_rob <= '0;
      r_iss_pay <= '0;
    end else if (io.BruFlash) begin
      r_vld     <= '0;
      r_cnt     <= '0;
      r_iss_vld <= 1'b0;
    end else begin
      r_vld     <= (r_vld & ~(w_iss ? w_gnt : '0)) | (w_enq ? w_free_oh : '0);
      r_cnt     <= r_cnt + CNT_W'(w_enq) - CNT_W'(w_iss);
      r_iss_vld <= w_iss;
      if (w_iss) begin
        r_iss_s1a <= w_sel_s1a;
        r_iss_s2a <= w_sel_s2a;
        r_iss_s1t <= w_sel_s1t;
        r_iss_s2t <= w_sel_s2t;
        r_iss_rob <= w_sel_rob;
        r_iss_pay <= w_sel_pay;
      end
    end
  end

  // Entry contents are only meaningful under r_vld, so they carry no reset
  always_ff @(posedge Clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_enq && w_free_oh[i]) begin
        r_s1a[i] <= io.EnqSrc1Able;
        r_s2a[i] <= io.EnqSrc2Able;
        r_s1t[i] <= io.EnqSrc1Addr;
        r_s2t[i] <= io.EnqSrc2Addr;
        r_s1r[i] <= io.EnqSrc1Rdy | ~io.EnqSrc1Able | w_enq_wk1;
        r_s2r[i] <= io.EnqSrc2Rdy | ~io.EnqSrc2Able | w_enq_wk2;
        r_rob[i] <= io.EnqRobPtr;
        r_pay[i] <= io.EnqPayload;
      end else begin
        r_s1r[i] <= r_s1r[i] | w_wk1[i];
        r_s2r[i] <= r_s2r[i] | w_wk2[i];
      end
    end
  end

  assign io.EnqReady    = w_enq_rdy;
  assign io.IssValid    = r_iss_vld;
  assign io.IssSrc1Able = r_iss_s1a;
  assign io.IssSrc2Able = r_iss_s2a;
  assign io.IssSrc1Addr = r_iss_s1t;
  assign io.IssSrc2Addr = r_iss_s2t;
  assign io.IssRobPtr   = r_iss_rob;
  assign io.IssPayload  = r_iss_pay;
  assign io.Occupancy   = r_cnt;
endmodule
